// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared definitions for the 9x8 PE array sequencer.
//   - pe_ctrl_state_t : sequencer FSM states
//   - PE_COLS/PE_ROWS : default array geometry
//   - PE_WAVE_DEPTH   : diagonal wavefront length (rows + cols - 1)
package pe_array_pkg;

    localparam int PE_COLS        = 8;
    localparam int PE_ROWS        = 9;
    localparam int PE_WAVE_DEPTH  = PE_ROWS + PE_COLS - 1;
    localparam int FMAP_LEN_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } pe_ctrl_state_t;

    // Wavefront depth for a non-default geometry.
    function automatic int wave_depth(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/pe_wavefront_gen.sv
// pe_wavefront_gen: systolic diagonal enable generator.
//   i_clk, i_rest   clock, async active-high reset
//   i_clear         synchronous flush of chain and psum_valid (abort)
//   i_rd_en         fmap read strobe; enters the chain one cycle later
//   o_left_en       bit c*ROWS+r enables PE (col c, row r) = diag[r+c]
//   o_right_en      left enable of the neighbour column; 0 in last column
//   o_psum_valid    bottom-row left enable of column c, delayed one cycle
//   o_empty_next    chain and psum_valid will both be empty next cycle
module pe_wavefront_gen
    import pe_array_pkg::*;
#(
    parameter int NUMBER_PE_COL = PE_COLS,
    parameter int NUMBER_PE_ROW = PE_ROWS
) (
    input  logic                                   i_clk,
    input  logic                                   i_rest,
    input  logic                                   i_clear,
    input  logic                                   i_rd_en,
    output logic [NUMBER_PE_COL*NUMBER_PE_ROW-1:0] o_left_en,
    output logic [NUMBER_PE_COL*NUMBER_PE_ROW-1:0] o_right_en,
    output logic [NUMBER_PE_COL-1:0]               o_psum_valid,
    output logic                                   o_empty_next
);

    localparam int DEPTH = wave_depth(NUMBER_PE_ROW, NUMBER_PE_COL);

    logic [DEPTH-1:0]         diag;
    logic [DEPTH-1:0]         diag_nxt;
    logic [NUMBER_PE_COL-1:0] psum_nxt;

    assign diag_nxt = {diag[DEPTH-2:0], i_rd_en};

    always_ff @(posedge i_clk or posedge i_rest) begin
        if (i_rest) begin
            diag         <= '0;
            o_psum_valid <= '0;
        end else if (i_clear) begin
            diag         <= '0;
            o_psum_valid <= '0;
        end else begin
            diag         <= diag_nxt;
            o_psum_valid <= psum_nxt;
        end
    end

    for (genvar c = 0; c < NUMBER_PE_COL; c++) begin : g_col
        for (genvar r = 0; r < NUMBER_PE_ROW; r++) begin : g_row
            assign o_left_en[c*NUMBER_PE_ROW+r] = diag[r+c];
            if (c < NUMBER_PE_COL - 1) begin : g_rgt
                assign o_right_en[c*NUMBER_PE_ROW+r] = diag[r+c+1];
            end else begin : g_last
                assign o_right_en[c*NUMBER_PE_ROW+r] = 1'b0;
            end
        end
        assign psum_nxt[c] = diag[NUMBER_PE_ROW-1+c];
    end

    // Look-ahead so DRAIN leaves in the cycle of the last psum, giving
    // o_done exactly one cycle after it.
    assign o_empty_next = ~|diag_nxt & ~|psum_nxt;

endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequencer for the floating-point PE array.
// Loads one weight set (valid/ready), streams i_fmap_len fmap vectors,
// drives the diagonal PE enables and flags bottom-row psums.
//   i_clk, i_rest        clock, async active-high reset
//   i_start, i_fmap_len  run request (IDLE only), vector count
//   i_w_valid/o_w_ready  weight set handshake; o_weight_en strobes next cycle
//   o_fmap_rd_en/addr    one fmap read per STREAM cycle
//   o_left_en/right_en   per-PE enables, bit c*NUMBER_PE_ROW+r
//   o_psum_valid         bottom-row psum valid per column
//   o_busy, o_done       not-IDLE flag, one-cycle completion pulse
// Optional macro PE_CTRL_ABORT_EN adds i_abort: forces IDLE, flushes the
// wavefront and counters, no o_done.
module pe_array_ctrl
    import pe_array_pkg::*;
#(
    parameter int NUMBER_PE_COL = PE_COLS,
    parameter int NUMBER_PE_ROW = PE_ROWS,
    parameter int FMAP_LEN_W    = FMAP_LEN_W_DEF
) (
    input  logic                                   i_clk,
    input  logic                                   i_rest,
    input  logic                                   i_start,
    input  logic [FMAP_LEN_W-1:0]                  i_fmap_len,
    input  logic                                   i_w_valid,
`ifdef PE_CTRL_ABORT_EN
    input  logic                                   i_abort,
`endif
    output logic                                   o_w_ready,
    output logic                                   o_weight_en,
    output logic                                   o_fmap_rd_en,
    output logic [FMAP_LEN_W-1:0]                  o_fmap_rd_addr,
    output logic [NUMBER_PE_COL*NUMBER_PE_ROW-1:0] o_left_en,
    output logic [NUMBER_PE_COL*NUMBER_PE_ROW-1:0] o_right_en,
    output logic [NUMBER_PE_COL-1:0]               o_psum_valid,
    output logic                                   o_busy,
    output logic                                   o_done
);

    pe_ctrl_state_t          state, state_nxt;
    logic [FMAP_LEN_W-1:0]   len_q;
    logic [FMAP_LEN_W-1:0]   cnt;
    logic                    last_rd;
    logic                    w_hs;
    logic                    abort_act;
    logic                    empty_next;

`ifdef PE_CTRL_ABORT_EN
    assign abort_act = i_abort && (state != ST_IDLE);
`else
    assign abort_act = 1'b0;
`endif

    assign last_rd        = (cnt == len_q - FMAP_LEN_W'(1));
    assign w_hs           = o_w_ready && i_w_valid;
    assign o_busy         = (state != ST_IDLE);
    assign o_fmap_rd_addr = cnt;

    always_comb begin
        state_nxt    = state;
        o_w_ready    = 1'b0;
        o_fmap_rd_en = 1'b0;
        o_done       = 1'b0;
        case (state)
            ST_IDLE: begin
                // A zero-length run spends one cycle in DRAIN (chain is
                // already empty) so its o_done lands two cycles after start.
                if (i_start)
                    state_nxt = (i_fmap_len == '0) ? ST_DRAIN : ST_WLOAD;
            end
            ST_WLOAD: begin
                o_w_ready = !abort_act;
                if (i_w_valid) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                o_fmap_rd_en = 1'b1;
                if (last_rd) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (empty_next) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_act) begin
            state_nxt = ST_IDLE;
            o_done    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rest) begin
        if (i_rest) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            cnt         <= '0;
            o_weight_en <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_weight_en <= w_hs;
            if (state == ST_IDLE && i_start)
                len_q <= i_fmap_len;
            // Counter returns to 0 after the last read so the address
            // output idles at 0 outside STREAM.
            if (abort_act || state != ST_STREAM || last_rd)
                cnt <= '0;
            else
                cnt <= cnt + FMAP_LEN_W'(1);
        end
    end

    pe_wavefront_gen #(
        .NUMBER_PE_COL (NUMBER_PE_COL),
        .NUMBER_PE_ROW (NUMBER_PE_ROW)
    ) u_wave (
        .i_clk        (i_clk),
        .i_rest       (i_rest),
        .i_clear      (abort_act),
        .i_rd_en      (o_fmap_rd_en),
        .o_left_en    (o_left_en),
        .o_right_en   (o_right_en),
        .o_psum_valid (o_psum_valid),
        .o_empty_next (empty_next)
    );

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: directed bench for pe_array_ctrl (default geometry).
// Cycle n is the interval after the n-th rising edge counted from the
// start pulse; inputs change and outputs are sampled near the falling edge.
module tb_pe_array_ctrl;
    localparam int COLS = 8;
    localparam int ROWS = 9;
    localparam int W    = 10;
    localparam int NPE  = COLS * ROWS;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W-1:0]    fmap_len;
    logic            w_valid;
    logic            abort;
    logic            w_ready, weight_en, rd_en, busy, done;
    logic [W-1:0]    rd_addr;
    logic [NPE-1:0]  left_en, right_en;
    logic [COLS-1:0] psum_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_array_ctrl dut (
        .i_clk          (clk),
        .i_rest         (rst),
        .i_start        (start),
        .i_fmap_len     (fmap_len),
        .i_w_valid      (w_valid),
`ifdef PE_CTRL_ABORT_EN
        .i_abort        (abort),
`endif
        .o_w_ready      (w_ready),
        .o_weight_en    (weight_en),
        .o_fmap_rd_en   (rd_en),
        .o_fmap_rd_addr (rd_addr),
        .o_left_en      (left_en),
        .o_right_en     (right_en),
        .o_psum_valid   (psum_valid),
        .o_busy         (busy),
        .o_done         (done)
    );

    typedef struct {
        int len;       // i_fmap_len at start
        int wdelay;    // cycles after start with i_w_valid low
        int ign_cyc;   // cycle of a stray i_start (len 7), -1 none
        int exp_h;     // expected handshake cycle
        int exp_done;  // expected o_done cycle
    } run_vec_t;

    run_vec_t vecs[6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // {w_ready, weight_en, rd_en, rd_addr, busy, done}
    function automatic logic [14:0] exp_ctrl(input int cyc, input int len, input int h, input int dn);
        logic wr, we, rd, bz, dd;
        logic [W-1:0] ad;
        wr = (len > 0) && cyc >= 1 && cyc <= h;
        we = (len > 0) && cyc == h + 1;
        rd = (len > 0) && cyc >= h + 1 && cyc <= h + len;
        ad = rd ? W'(cyc - h - 1) : '0;
        bz = cyc >= 1 && cyc <= dn;
        dd = cyc == dn;
        return {wr, we, rd, ad, bz, dd};
    endfunction

    // {psum_valid, left_en, right_en}; vector k reaches PE(c,r) at h+2+k+r+c
    function automatic logic [COLS+2*NPE-1:0] exp_wave(input int cyc, input int len, input int h);
        logic [NPE-1:0]  l, rg;
        logic [COLS-1:0] p;
        int d;
        l = '0; rg = '0; p = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) begin
                d = cyc - r - c;
                l[c*ROWS+r] = (len > 0) && d >= h + 2 && d <= h + 1 + len;
            end
        for (int c = 0; c < COLS - 1; c++)
            for (int r = 0; r < ROWS; r++)
                rg[c*ROWS+r] = l[(c+1)*ROWS+r];
        for (int c = 0; c < COLS; c++) begin
            d = cyc - ROWS - c;
            p[c] = (len > 0) && d >= h + 2 && d <= h + 1 + len;
        end
        return {p, l, rg};
    endfunction

    task automatic run_one(input run_vec_t v);
        for (int cyc = 0; cyc <= v.exp_done + 2; cyc++) begin
            @(negedge clk);
            start    = (cyc == 0) || (cyc == v.ign_cyc);
            fmap_len = (cyc == 0) ? W'(v.len) : W'(7);
            w_valid  = (v.wdelay == 0) || (cyc >= 1 + v.wdelay);
            #1;
            check($sformatf("len%0d wd%0d c%0d ctrl", v.len, v.wdelay, cyc),
                  {w_ready, weight_en, rd_en, rd_addr, busy, done},
                  exp_ctrl(cyc, v.len, v.exp_h, v.exp_done));
            check($sformatf("len%0d wd%0d c%0d wave", v.len, v.wdelay, cyc),
                  {psum_valid, left_en, right_en},
                  exp_wave(cyc, v.len, v.exp_h));
        end
        start   = 1'b0;
        w_valid = 1'b0;
    endtask

    initial begin
        vecs = '{
            '{4, 0, -1, 1, 23},   // baseline
            '{0, 0, -1, 0, 2},    // zero length
            '{4, 10, -1, 11, 33}, // weight stall
            '{4, 0, 3, 1, 23},    // stray start in STREAM
            '{1, 0, 20, 1, 20},   // single vector, stray start in DONE
            '{2, 3, 6, 4, 24}     // short stall, stray start on last read
        };
        rst = 1'b1; start = 1'b0; fmap_len = '0; w_valid = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset outputs",
              {w_ready, weight_en, rd_en, rd_addr, busy, done, psum_valid, left_en, right_en}, '0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_one(vecs[i]);

        // Asynchronous reset in the middle of STREAM.
        @(negedge clk); start = 1'b1; fmap_len = W'(4); w_valid = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("pre-reset c3 ctrl", {w_ready, weight_en, rd_en, rd_addr, busy, done},
              exp_ctrl(3, 4, 1, 23));
        #2 rst = 1'b1;
        #1;
        check("async reset",
              {w_ready, weight_en, rd_en, rd_addr, busy, done, psum_valid, left_en, right_en}, '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0; w_valid = 1'b0;
        run_one('{2, 0, -1, 1, 21});

`ifdef PE_CTRL_ABORT_EN
        // Abort on the third read (cycle 4); no done afterwards.
        for (int cyc = 0; cyc <= 26; cyc++) begin
            @(negedge clk);
            start    = (cyc == 0);
            fmap_len = W'(4);
            w_valid  = 1'b1;
            abort    = (cyc == 4);
            #1;
            if (cyc <= 4)
                check($sformatf("abort c%0d ctrl", cyc),
                      {w_ready, weight_en, rd_en, rd_addr, busy, done}, exp_ctrl(cyc, 4, 1, 23));
            else begin
                check($sformatf("abort c%0d ctrl", cyc),
                      {w_ready, weight_en, rd_en, rd_addr, busy, done}, '0);
                check($sformatf("abort c%0d wave", cyc), {psum_valid, left_en, right_en}, '0);
            end
        end
        abort = 1'b0; w_valid = 1'b0;
        run_one('{1, 0, -1, 1, 20});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
